// File: rtl/axi_stream_demux_4_pkg.sv
// Shared types for the four-way AXI-stream demultiplexer.
// The route index selects one of the N_OUTPUTS streams and is held for a whole packet.
package axis_demux_pkg;

    localparam int N_OUTPUTS = 4;

    typedef logic [1:0] route_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } route_state_t;

endpackage

// File: rtl/axi_stream_demux_4_if.sv
// AXI-stream bundle used on both sides of the demultiplexer.
// Master drives payload and valid. Slave drives ready.
interface axi_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  tlast;
    logic                  valid;
    logic                  ready;

    modport master (
        output data,
        output dest,
        output user,
        output tlast,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  dest,
        input  user,
        input  tlast,
        input  valid,
        output ready
    );
endinterface

// File: rtl/axi_stream_demux_4_skid_buffer.sv
// Two-entry register slice: an output register backed by one skid register.
// in_ready depends only on this slice's own skid state, so each output stalls independently.
module axi_stream_skid_buffer #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_payload,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_payload,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_payload_q, out_payload_d;
    logic             skid_full_q, skid_full_d;
    logic [WIDTH-1:0] skid_payload_q, skid_payload_d;
    logic             push;
    logic             drain;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_payload_q  <= '0;
            skid_full_q    <= 1'b0;
            skid_payload_q <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_payload_q  <= out_payload_d;
            skid_full_q    <= skid_full_d;
            skid_payload_q <= skid_payload_d;
        end
    end

    // The skid register is only filled while the output register is full and stalled,
    // so a full skid always has priority when the output register frees up.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_payload_d  = out_payload_q;
        skid_full_d    = skid_full_q;
        skid_payload_d = skid_payload_q;
        push           = in_valid && !skid_full_q;
        drain          = out_valid_q && out_ready;

        if (drain || !out_valid_q) begin
            if (skid_full_q) begin
                out_valid_d   = 1'b1;
                out_payload_d = skid_payload_q;
                skid_full_d   = 1'b0;
            end else if (push) begin
                out_valid_d   = 1'b1;
                out_payload_d = in_payload;
            end else begin
                out_valid_d   = 1'b0;
            end
        end else if (push) begin
            skid_full_d    = 1'b1;
            skid_payload_d = in_payload;
        end
    end

    assign in_ready    = !skid_full_q;
    assign out_valid   = out_valid_q;
    assign out_payload = out_payload_q;

endmodule

// File: rtl/axi_stream_demux_4.sv
// Four-way AXI-stream demultiplexer with per-packet route locking.
// Each output sits behind its own skid buffer, giving one cycle of latency.
module axi_stream_demux_4
    import axis_demux_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DEST_WIDTH    = 8,
    parameter int USER_WIDTH    = 32,
    parameter int ROUTE_BY_DEST = 0,
    parameter int DEST_SHIFT    = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] address,
    axi_stream.slave   stream_in,
    axi_stream.master  stream_out_1,
    axi_stream.master  stream_out_2,
    axi_stream.master  stream_out_3,
    axi_stream.master  stream_out_4
);

    localparam int PW = DATA_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

    route_state_t   state_q, state_d;
    route_t         route_q, route_d;
    route_t         route_sel;
    logic           in_ready;
    logic           accept;
    logic [PW-1:0]  in_payload;
    logic [N_OUTPUTS-1:0] push;
    logic [N_OUTPUTS-1:0] skid_ready;
    logic [N_OUTPUTS-1:0] out_valid;
    logic [N_OUTPUTS-1:0] out_ready;
    logic [PW-1:0]  out_payload [N_OUTPUTS];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    // A packet's route is captured on its first beat and released by its tlast beat.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        case (state_q)
            IDLE: begin
                if (accept && !stream_in.tlast) begin
                    state_d = LOCKED;
                    route_d = route_sel;
                end
            end
            LOCKED: begin
                if (accept && stream_in.tlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        route_sel = route_q;
        if (state_q == IDLE) begin
            route_sel = (ROUTE_BY_DEST != 0) ? stream_in.dest[DEST_SHIFT+1:DEST_SHIFT] : address;
        end
        in_ready = !reset && skid_ready[route_sel];
        accept   = stream_in.valid && in_ready;
        push     = '0;
        for (int i = 0; i < N_OUTPUTS; i++) begin
            push[i] = accept && (route_sel == route_t'(i));
        end
    end

    assign stream_in.ready = in_ready;
    assign in_payload = {stream_in.data, stream_in.dest, stream_in.user, stream_in.tlast};

    for (genvar g = 0; g < N_OUTPUTS; g++) begin : g_out
        axi_stream_skid_buffer #(
            .WIDTH (PW)
        ) u_skid (
            .clock       (clock),
            .reset       (reset),
            .in_valid    (push[g]),
            .in_payload  (in_payload),
            .in_ready    (skid_ready[g]),
            .out_valid   (out_valid[g]),
            .out_payload (out_payload[g]),
            .out_ready   (out_ready[g])
        );
    end

    assign out_ready = {stream_out_4.ready, stream_out_3.ready, stream_out_2.ready, stream_out_1.ready};

    assign stream_out_1.valid = out_valid[0];
    assign stream_out_2.valid = out_valid[1];
    assign stream_out_3.valid = out_valid[2];
    assign stream_out_4.valid = out_valid[3];

    assign {stream_out_1.data, stream_out_1.dest, stream_out_1.user, stream_out_1.tlast} = out_payload[0];
    assign {stream_out_2.data, stream_out_2.dest, stream_out_2.user, stream_out_2.tlast} = out_payload[1];
    assign {stream_out_3.data, stream_out_3.dest, stream_out_3.user, stream_out_3.tlast} = out_payload[2];
    assign {stream_out_4.data, stream_out_4.dest, stream_out_4.user, stream_out_4.tlast} = out_payload[3];

endmodule
